// File: rtl/fetch_queue_if.sv
// Fetch-stage channels: instruction-memory request/response, branch redirect, and the decode handoff.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential prefetch into a DEPTH-slot queue; a response reaches decode one edge after capture (no bypass).
// Slots are reserved at request time so responses are never back-pressured; decode stalls hold the head.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      reset,
  fetch_queue_if.master bus
);
  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL     = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]    head, tail, fill;
  logic [PW:0]      used, drop;
  logic             run;

  logic             req_hs, rsp_keep, rsp_drop, dec_hs;
  logic [PW:0]      filled_cnt, unfilled, drop_red;
  logic [PW+1:0]    drop_sum, drop_diff;

  // run holds request valid off until the first edge after reset release
  assign bus.imem_req_valid = run && (used < FULL);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.dec_valid      = slot_filled[head];
  assign bus.dec_instr      = slot_instr[head];
  assign bus.dec_pc         = slot_pc[head];
  assign bus.dec_pc_plus4   = slot_filled[head] ? slot_pc[head] + PC_STEP : '0;

  assign req_hs   = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && (drop == '0);
  assign rsp_drop = bus.imem_rsp_valid && (drop != '0);
  assign dec_hs   = bus.dec_valid && bus.dec_ready;

  // In-flight responses still owed to the current queue are those reserved but not yet filled.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + (PW+1)'(slot_filled[i]);
    end
    unfilled  = used - filled_cnt;
    drop_sum  = {1'b0, drop} + {1'b0, unfilled} + (PW+2)'(req_hs);
    drop_diff = drop_sum - (PW+2)'(bus.imem_rsp_valid);
    drop_red  = (drop_sum > (PW+2)'(bus.imem_rsp_valid)) ? drop_diff[PW:0] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      used        <= '0;
      drop        <= '0;
      run         <= 1'b0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc    <= bus.redirect_pc;
        head        <= '0;
        tail        <= '0;
        fill        <= '0;
        used        <= '0;
        drop        <= drop_red;
        slot_filled <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          slot_pc[i]    <= '0;
          slot_instr[i] <= '0;
        end
      end else begin
        // tail, fill and head always index distinct slots when their handshakes coincide
        if (req_hs) begin
          slot_pc[tail]     <= fetch_pc;
          slot_instr[tail]  <= '0;
          slot_filled[tail] <= 1'b0;
          tail              <= tail + PTR_ONE;
          fetch_pc          <= fetch_pc + PC_STEP;
        end
        if (rsp_keep) begin
          slot_instr[fill]  <= bus.imem_rsp_data;
          slot_filled[fill] <= 1'b1;
          fill              <= fill + PTR_ONE;
        end
        if (rsp_drop) begin
          drop <= drop - (PW+1)'(1);
        end
        if (dec_hs) begin
          slot_pc[head]     <= '0;
          slot_instr[head]  <= '0;
          slot_filled[head] <= 1'b0;
          head              <= head + PTR_ONE;
        end
        used <= used + (PW+1)'(req_hs) - (PW+1)'(dec_hs);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench: a variable-latency in-order memory feeds the DUT; a scoreboard of expected fetch PCs checks decode.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) bus();
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // memory model: in-order, each request answered lat cycles later, at most DEPTH outstanding
  typedef struct { logic [31:0] addr; int rt; } mreq_t;
  mreq_t mq[$];
  int    last_rt = 0;
  int    cyc = 0;
  int    lat_min = 1, lat_max = 1, p_dec = 100, p_req = 100, p_redir = 0;
  logic        force_redir = 1'b0;
  logic [31:0] redir_tgt = '0;

  task automatic cycle();
    int lat, rt;
    @(negedge clk);
    cyc++;
    if (mq.size() > 0 && mq[0].rt <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.dec_ready      = ($urandom_range(99) < p_dec);
    bus.imem_req_ready = ($urandom_range(99) < p_req) && (mq.size() < DEPTH);
    if (force_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_tgt;
      force_redir        = 1'b0;
    end else if ($urandom_range(999) < p_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                                    : ($urandom & 32'h0000_FFFC);
    end else begin
      bus.redirect_valid = 1'b0;
    end
    #2;
    if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      rt  = cyc + lat;
      if (rt <= last_rt) rt = last_rt + 1;
      last_rt = rt;
      mq.push_back('{bus.imem_req_addr, rt});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // scoreboard: expected decode PCs in program order along the current path
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int req_cnt = 0, dec_cnt = 0;
  int first_req_cyc = -1, first_dec_cyc = -1;
  logic gap_watch = 1'b0, gap_seen = 1'b0;
  logic after_redir = 1'b0;
  logic [31:0] first_pc = '0, first_p4 = '1;
  logic redir_combo = 1'b0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        exp_q.delete();
        model_pc    = RESET_PC;
        after_redir = 1'b0;
      end else begin
        if (bus.imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
        if (bus.dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
        if (gap_watch && first_dec_cyc >= 0 && !bus.dec_valid) gap_seen = 1'b1;
        if (bus.dec_valid && bus.dec_ready) begin
          dec_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dec_unexpected got pc %h expected none", bus.dec_pc);
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", bus.dec_pc, e);
            chk("dec_instr", bus.dec_instr, instr_of(e));
            chk("dec_pc_plus4", bus.dec_pc_plus4, e + 32'd4);
          end
          if (after_redir) begin
            first_pc    = bus.dec_pc;
            first_p4    = bus.dec_pc_plus4;
            after_redir = 1'b0;
          end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          req_cnt++;
          chk("req_addr", bus.imem_req_addr, model_pc);
          exp_q.push_back(model_pc);
          model_pc = model_pc + 32'd4;
        end
        if (bus.redirect_valid) begin
          redir_combo = bus.imem_req_valid && bus.imem_req_ready && bus.imem_rsp_valid;
          exp_q.delete();
          model_pc    = bus.redirect_pc;
          after_redir = 1'b1;
        end
      end
    end
  end

  initial begin
    int r0;
    reset              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    run(2);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_instr", bus.dec_instr, 32'd0);
    chk("rst_dec_pc", bus.dec_pc, 32'd0);
    chk("rst_dec_pc_plus4", bus.dec_pc_plus4, 32'd0);
    reset = 1'b1;

    // zero-wait streaming from reset
    gap_watch = 1'b1;
    run(20);
    gap_watch = 1'b0;
    chk("req_to_dec_latency", first_dec_cyc - first_req_cyc, 32'd2);
    chk("stream_gapless", 32'(gap_seen), 32'd0);

    // build up state, then reset asynchronously mid-cycle
    lat_min = 3; lat_max = 3; p_dec = 0;
    run(3);
    chk("pre_rst_dec_valid", 32'(bus.dec_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("async_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    mq.delete();
    bus.imem_rsp_valid = 1'b0;
    run(2);
    reset = 1'b1;

    // decode stall: only DEPTH requests may issue
    lat_min = 1; lat_max = 1;
    r0 = req_cnt;
    run(10);
    #2;
    chk("stall_req_count", req_cnt - r0, 32'd4);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    p_dec = 100;
    run(12);

    // redirect with three stale responses in flight
    lat_min = 3; lat_max = 3;
    run(6);
    redir_tgt = 32'h100; force_redir = 1'b1;
    run(15);
    chk("redir_req_and_rsp_same_cycle", 32'(redir_combo), 32'd1);
    chk("redir_first_dec_pc", first_pc, 32'h100);

    // address wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    redir_tgt = 32'hFFFF_FFFC; force_redir = 1'b1;
    run(10);
    chk("wrap_first_dec_pc", first_pc, 32'hFFFF_FFFC);
    chk("wrap_first_pc_plus4", first_p4, 32'h0);

    // randomized traffic
    lat_min = 1; lat_max = 5; p_dec = 70; p_req = 70; p_redir = 30;
    run(3000);
    p_redir = 0; p_dec = 100; p_req = 100;
    run(30);
    chk("random_traffic_progress", 32'(dec_cnt > 1000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
